// File: rtl/bram_accumulator.sv
// bram_accumulator: single-port synchronous block RAM with a host read/write
// port and a built-in burst accumulator that sums len consecutive words from
// base_addr, wrapping at the top of memory.
// Build option: define BRAM_ACC_SAT_EN to saturate the sum at 2**DATA_W-1
// and turn c_out into a sticky overflow flag.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | host port live, waiting for start
// RUN    | one burst read per cycle, accumulating the previous read
// FINISH | accumulate last word, pulse done, release the host port
module bram_accumulator #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     write_en,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        data_in,
    output logic [DATA_W-1:0]        data_out,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W:0]          len,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W+ADDR_W-1:0] sum,
    output logic                     c_out
);

    localparam int SUM_W = DATA_W + ADDR_W;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              rd_valid;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic [SUM_W-1:0]  sum_add;
    logic [SUM_W-1:0]  next_sum;
    logic              next_c;
    logic              host_ok;

    // The host port is locked out for the whole burst, including FINISH.
    assign host_ok = enable && !busy;
    assign sum_add = sum + SUM_W'(rd_q);

    // Next accumulator value and carry flag for one more word.
    always_comb begin
        next_sum = sum_add;
        next_c   = |sum_add[SUM_W-1:DATA_W];
`ifdef BRAM_ACC_SAT_EN
        // sum never exceeds 2**DATA_W-1 here, so sum_add cannot wrap SUM_W.
        if (|sum_add[SUM_W-1:DATA_W]) begin
            next_sum = {{ADDR_W{1'b0}}, {DATA_W{1'b1}}};
            next_c   = 1'b1;
        end else begin
            next_c   = c_out;
        end
`endif
    end

    // RAM array: host writes and burst reads share the single port; not reset.
    always_ff @(posedge clk) begin
        if (host_ok && write_en) begin
            mem[addr] <= data_in;
        end
        if (state == RUN) begin
            rd_q <= mem[ptr];
        end
    end

    // Registered host read data, read-first, held when not reading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (host_ok && !write_en) begin
            data_out <= mem[addr];
        end
    end

    // Burst sequencer with registered busy/done/sum/c_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            rd_valid  <= 1'b0;
            ptr       <= '0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr       <= base_addr;
                        remaining <= (len > LEN_MAX) ? LEN_MAX : len;
                        sum       <= '0;
                        c_out     <= 1'b0;
                        rd_valid  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (len == '0) ? FINISH : RUN;
                    end
                end
                RUN: begin
                    ptr      <= ptr + 1'b1;
                    rd_valid <= 1'b1;
                    if (rd_valid) begin
                        sum   <= next_sum;
                        c_out <= next_c;
                    end
                    if (remaining == LEN_ONE) begin
                        state <= FINISH;
                    end else begin
                        remaining <= remaining - 1'b1;
                    end
                end
                FINISH: begin
                    if (rd_valid) begin
                        sum   <= next_sum;
                        c_out <= next_c;
                    end
                    rd_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
